// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and types for the RTC access scheduler.
// Holds the RTC register map used by the sweep, the sweep length and
// the scheduler FSM state encoding.
package rtc_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SWEEP_LEN = 10;
    localparam int unsigned IDX_W     = 4;

    // RTC register addresses
    localparam logic [DATA_W-1:0] RTC_ADDR_CMD    = 8'hF0;
    localparam logic [DATA_W-1:0] RTC_ADDR_YEAR   = 8'h26;
    localparam logic [DATA_W-1:0] RTC_ADDR_MES    = 8'h25;
    localparam logic [DATA_W-1:0] RTC_ADDR_DIA    = 8'h24;
    localparam logic [DATA_W-1:0] RTC_ADDR_HORA   = 8'h23;
    localparam logic [DATA_W-1:0] RTC_ADDR_MIN    = 8'h22;
    localparam logic [DATA_W-1:0] RTC_ADDR_SEG    = 8'h21;
    localparam logic [DATA_W-1:0] RTC_ADDR_HCRONO = 8'h43;
    localparam logic [DATA_W-1:0] RTC_ADDR_MCRONO = 8'h42;
    localparam logic [DATA_W-1:0] RTC_ADDR_SCRONO = 8'h41;

    // Scheduler FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    // Address of the sweep item at a given index (index 0 is the latch command)
    function automatic logic [DATA_W-1:0] sweep_addr(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] a;
        case (idx)
            4'd1:    a = RTC_ADDR_YEAR;
            4'd2:    a = RTC_ADDR_MES;
            4'd3:    a = RTC_ADDR_DIA;
            4'd4:    a = RTC_ADDR_HORA;
            4'd5:    a = RTC_ADDR_MIN;
            4'd6:    a = RTC_ADDR_SEG;
            4'd7:    a = RTC_ADDR_HCRONO;
            4'd8:    a = RTC_ADDR_MCRONO;
            4'd9:    a = RTC_ADDR_SCRONO;
            default: a = RTC_ADDR_CMD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// rtc_refresh_timer: free-running counter that emits a one-cycle tick
// every PERIOD clocks (registered, high in the cycle after the wrap edge).
// Ports: clk_i, rst_ni (async active-low), tick_o.
module rtc_refresh_timer #(
    parameter int unsigned PERIOD = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count and wrap detection
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/rtc_access_sched.sv
// rtc_access_sched: transaction scheduler for the shared RTC bus.
// Runs a 10-item sweep (latch command + nine reads) on refresh tick or chs
// rising edge, interleaves user writes at transaction boundaries, and
// holds the captured time/date/timer registers.
// Ports: clock/reset (async active-low); chs manual trigger; wr_req/wr_addr/
// wr_data/wr_ack user write; txn_* valid/done handshake to the bus engine;
// year..segcrono, AmPm captured data; busy, sweep_done, err status.
module rtc_access_sched
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT        = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chs,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       txn_valid,
    output logic       txn_write,
    output logic [7:0] txn_addr,
    output logic [7:0] txn_wdata,
    input  logic       txn_done,
    input  logic [7:0] txn_rdata,
    output logic [7:0] year,
    output logic [7:0] mes,
    output logic [7:0] dia,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic [7:0] horacrono,
    output logic [7:0] mincrono,
    output logic [7:0] segcrono,
    output logic       AmPm,
    output logic       busy,
    output logic       sweep_done,
    output logic       err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SWEEP_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             pend_q, pend_d;
    logic             user_q, user_d;
    logic             chs_q;
    logic             valid_q, valid_d;
    logic             write_q, write_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_ack_q, wr_ack_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       year_q, year_d, mes_q, mes_d, dia_q, dia_d;
    logic [7:0]       hora_q, hora_d, min_q, min_d, seg_q, seg_d;
    logic [7:0]       hcr_q, hcr_d, mcr_q, mcr_d, scr_q, scr_d;
    logic             ampm_q, ampm_d;
    logic             tick;
    logic             sweep_req_c;

    rtc_refresh_timer #(
        .PERIOD (REFRESH_CYCLES)
    ) u_refresh (
        .clk_i  (clock),
        .rst_ni (reset),
        .tick_o (tick)
    );

    // Simultaneous chs edge and refresh tick collapse into one request
    assign sweep_req_c = (chs & ~chs_q) | tick;

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        busy_d   = busy_q;
        pend_d   = pend_q | sweep_req_c;
        user_d   = user_q;
        valid_d  = valid_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_ack_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        year_d   = year_q;
        mes_d    = mes_q;
        dia_d    = dia_q;
        hora_d   = hora_q;
        min_d    = min_q;
        seg_d    = seg_q;
        hcr_d    = hcr_q;
        mcr_d    = mcr_q;
        scr_d    = scr_q;
        ampm_d   = ampm_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    // User write wins every boundary; the sweep index is left alone
                    state_d = ST_ISSUE;
                    user_d  = 1'b1;
                    write_d = 1'b1;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                end else if (pend_q || busy_q) begin
                    state_d = ST_ISSUE;
                    user_d  = 1'b0;
                    write_d = (idx_q == '0);
                    addr_d  = sweep_addr(idx_q);
                    wdata_d = 8'h00;
                    if (idx_q == '0) begin
                        busy_d = 1'b1;
                        pend_d = sweep_req_c;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                valid_d = 1'b1;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (txn_done) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    if (user_q) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        case (idx_q)
                            4'd1: year_d = txn_rdata;
                            4'd2: mes_d  = txn_rdata;
                            4'd3: dia_d  = txn_rdata;
                            4'd4: begin
                                hora_d = {1'b0, txn_rdata[6:0]};
                                ampm_d = txn_rdata[7];
                            end
                            4'd5: min_d  = txn_rdata;
                            4'd6: seg_d  = txn_rdata;
                            4'd7: hcr_d  = txn_rdata;
                            4'd8: mcr_d  = txn_rdata;
                            4'd9: scr_d  = txn_rdata;
                            default: ;
                        endcase
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: drop the request and restart any sweep from scratch
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            user_q   <= 1'b0;
            chs_q    <= 1'b0;
            valid_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= 8'hFF;
            wdata_q  <= 8'hFF;
            wr_ack_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            year_q   <= 8'h00;
            mes_q    <= 8'h00;
            dia_q    <= 8'h00;
            hora_q   <= 8'h80;
            min_q    <= 8'h00;
            seg_q    <= 8'h00;
            hcr_q    <= 8'h00;
            mcr_q    <= 8'h00;
            scr_q    <= 8'h00;
            ampm_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            user_q   <= user_d;
            chs_q    <= chs;
            valid_q  <= valid_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_ack_q <= wr_ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            year_q   <= year_d;
            mes_q    <= mes_d;
            dia_q    <= dia_d;
            hora_q   <= hora_d;
            min_q    <= min_d;
            seg_q    <= seg_d;
            hcr_q    <= hcr_d;
            mcr_q    <= mcr_d;
            scr_q    <= scr_d;
            ampm_q   <= ampm_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign txn_valid  = valid_q;
    assign txn_write  = write_q;
    assign txn_addr   = addr_q;
    assign txn_wdata  = wdata_q;
    assign year       = year_q;
    assign mes        = mes_q;
    assign dia        = dia_q;
    assign hora       = hora_q;
    assign min        = min_q;
    assign seg        = seg_q;
    assign horacrono  = hcr_q;
    assign mincrono   = mcr_q;
    assign segcrono   = scr_q;
    assign AmPm       = ampm_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Directed bench for rtc_access_sched: one instance with a long refresh
// period for sweep/write/timeout/reset scenarios, and one with a 100-cycle
// refresh period for automatic sweep scheduling.
module tb_rtc_access_sched;

    logic       clock, reset;
    logic       chs, wr_req;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack, txn_valid, txn_write, txn_done;
    logic [7:0] txn_addr, txn_wdata, txn_rdata;
    logic [7:0] year, mes, dia, hora, min, seg, horacrono, mincrono, segcrono;
    logic       AmPm, busy, sweep_done, err;

    logic       chs_b, wr_ack_b, txn_valid_b, txn_write_b, txn_done_b;
    logic [7:0] txn_addr_b, txn_wdata_b, txn_rdata_b;
    logic [7:0] year_b, mes_b, dia_b, hora_b, min_b, seg_b, hcr_b, mcr_b, scr_b;
    logic       AmPm_b, busy_b, sweep_done_b, err_b;

    rtc_access_sched #(.REFRESH_CYCLES(1_000_000), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .chs(chs), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .txn_valid(txn_valid), .txn_write(txn_write), .txn_addr(txn_addr),
        .txn_wdata(txn_wdata), .txn_done(txn_done), .txn_rdata(txn_rdata),
        .year(year), .mes(mes), .dia(dia), .hora(hora), .min(min), .seg(seg),
        .horacrono(horacrono), .mincrono(mincrono), .segcrono(segcrono),
        .AmPm(AmPm), .busy(busy), .sweep_done(sweep_done), .err(err)
    );

    rtc_access_sched #(.REFRESH_CYCLES(100), .TIMEOUT(16)) dut_b (
        .clock(clock), .reset(reset), .chs(chs_b), .wr_req(1'b0),
        .wr_addr(8'h00), .wr_data(8'h00), .wr_ack(wr_ack_b),
        .txn_valid(txn_valid_b), .txn_write(txn_write_b), .txn_addr(txn_addr_b),
        .txn_wdata(txn_wdata_b), .txn_done(txn_done_b), .txn_rdata(txn_rdata_b),
        .year(year_b), .mes(mes_b), .dia(dia_b), .hora(hora_b), .min(min_b), .seg(seg_b),
        .horacrono(hcr_b), .mincrono(mcr_b), .segcrono(scr_b),
        .AmPm(AmPm_b), .busy(busy_b), .sweep_done(sweep_done_b), .err(err_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Bus engine model for dut: done 5 cycles after txn_valid, logs each transaction
    logic [7:0] rtc_mem [256];
    logic [7:0] tr_addr [64];
    logic [7:0] tr_wdata [64];
    logic       tr_wr [64];
    int         tr_n;
    int         lat_a;
    bit         hang;

    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
        rtc_mem[8'h26] = 8'h16; rtc_mem[8'h25] = 8'h03; rtc_mem[8'h24] = 8'h23;
        rtc_mem[8'h23] = 8'h85; rtc_mem[8'h22] = 8'h59; rtc_mem[8'h21] = 8'h30;
        rtc_mem[8'h43] = 8'h01; rtc_mem[8'h42] = 8'h02; rtc_mem[8'h41] = 8'h03;
        txn_done = 1'b0; txn_rdata = 8'h00; lat_a = 0; tr_n = 0;
        forever begin
            @(negedge clock);
            if (txn_done) begin
                txn_done = 1'b0;
                lat_a = 0;
            end else if (txn_valid && !hang) begin
                lat_a++;
                if (lat_a == 5) begin
                    txn_done = 1'b1;
                    lat_a = 0;
                    if (tr_n < 64) begin
                        tr_addr[tr_n]  = txn_addr;
                        tr_wdata[tr_n] = txn_wdata;
                        tr_wr[tr_n]    = txn_write;
                    end
                    tr_n++;
                    if (txn_write) rtc_mem[txn_addr] = txn_wdata;
                    else txn_rdata = rtc_mem[txn_addr];
                end
            end else begin
                lat_a = 0;
            end
        end
    end

    // Bus engine model for dut_b: done 2 cycles after txn_valid, read data 0
    int lat_b;
    initial begin
        txn_done_b = 1'b0; txn_rdata_b = 8'h00; lat_b = 0;
        forever begin
            @(negedge clock);
            if (txn_done_b) begin
                txn_done_b = 1'b0;
                lat_b = 0;
            end else if (txn_valid_b) begin
                lat_b++;
                if (lat_b == 2) begin
                    txn_done_b = 1'b1;
                    lat_b = 0;
                end
            end else begin
                lat_b = 0;
            end
        end
    end

    // Cycle count since reset release
    int cyc;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            if (!reset) cyc = 0;
            else cyc++;
        end
    end

    // Pulse counters and sweep-start log
    int n_done, n_ack, n_err, n_done_b, n_start_b;
    int starts_b [8];
    logic vb_prev;
    initial begin
        n_done = 0; n_ack = 0; n_err = 0; n_done_b = 0; n_start_b = 0; vb_prev = 1'b0;
        for (int i = 0; i < 8; i++) starts_b[i] = 0;
        forever begin
            @(negedge clock);
            if (sweep_done) n_done++;
            if (wr_ack) n_ack++;
            if (err) n_err++;
            if (sweep_done_b) n_done_b++;
            if (txn_valid_b && !vb_prev && txn_write_b && txn_addr_b == 8'hF0) begin
                if (n_start_b < 8) starts_b[n_start_b] = cyc;
                n_start_b++;
            end
            vb_prev = txn_valid_b;
        end
    end

    int passed, total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_chs();
        chs = 1'b1;
        tick();
        chs = 1'b0;
    endtask

    task automatic wait_sweep_done(input string tag);
        int k;
        k = 0;
        while (!sweep_done && k < 400) begin
            tick();
            k++;
        end
        check(tag, 32'(sweep_done), 32'h1);
    endtask

    logic [7:0] exp_addr [10];
    int base, base2, d0, a0, e0, k, n;

    initial begin
        exp_addr = '{8'hF0, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
        passed = 0; total = 0; hang = 1'b0;
        reset = 1'b0; chs = 1'b0; chs_b = 1'b0;
        wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        repeat (3) tick();

        // Reset values
        check("rst_txn_valid", 32'(txn_valid), 32'h0);
        check("rst_txn_write", 32'(txn_write), 32'h0);
        check("rst_txn_addr", 32'(txn_addr), 32'hFF);
        check("rst_txn_wdata", 32'(txn_wdata), 32'hFF);
        check("rst_wr_ack", 32'(wr_ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sweep_done", 32'(sweep_done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ampm", 32'(AmPm), 32'h0);
        check("rst_hora", 32'(hora), 32'h80);
        check("rst_year", 32'(year), 32'h00);
        check("rst_segcrono", 32'(segcrono), 32'h00);

        @(negedge clock);
        reset = 1'b1;

        // Automatic refresh on dut_b, with a chs during the first sweep
        while (cyc < 130) tick();
        check("b_busy_mid_sweep", 32'(busy_b), 32'h1);
        chs_b = 1'b1;
        tick();
        chs_b = 1'b0;
        while (cyc < 295) tick();
        check("b_sweep_starts", 32'(n_start_b), 32'd3);
        check("b_first_start_near_period", 32'(starts_b[0] >= 100 && starts_b[0] <= 104), 32'h1);
        check("b_refresh_period", 32'(starts_b[2] - starts_b[0]), 32'd100);
        check("b_extra_sweep_between", 32'(starts_b[1] > starts_b[0] && starts_b[1] < starts_b[2]), 32'h1);
        check("b_sweeps_done", 32'(n_done_b), 32'd3);
        check("b_no_err", 32'(err_b), 32'h0);

        // Full sweep on chs
        base = tr_n; d0 = n_done;
        pulse_chs();
        wait_sweep_done("s1_sweep_done");
        check("s1_year", 32'(year), 32'h16);
        check("s1_mes", 32'(mes), 32'h03);
        check("s1_dia", 32'(dia), 32'h23);
        check("s1_hora", 32'(hora), 32'h05);
        check("s1_ampm", 32'(AmPm), 32'h1);
        check("s1_min", 32'(min), 32'h59);
        check("s1_seg", 32'(seg), 32'h30);
        check("s1_horacrono", 32'(horacrono), 32'h01);
        check("s1_mincrono", 32'(mincrono), 32'h02);
        check("s1_segcrono", 32'(segcrono), 32'h03);
        check("s1_busy_clear", 32'(busy), 32'h0);
        check("s1_txn_count", 32'(tr_n - base), 32'd10);
        check("s1_cmd_is_write", 32'(tr_wr[base]), 32'h1);
        check("s1_cmd_data", 32'(tr_wdata[base]), 32'h00);
        for (int i = 0; i < 10; i++) check("s1_sweep_addr", 32'(tr_addr[base + i]), 32'(exp_addr[i]));
        check("s1_last_is_read", 32'(tr_wr[base + 9]), 32'h0);
        tick();
        check("s1_done_one_cycle", 32'(sweep_done), 32'h0);
        check("s1_done_count", 32'(n_done - d0), 32'd1);

        // User write raised during index 4 (hora read)
        base = tr_n; a0 = n_ack;
        pulse_chs();
        k = 0;
        while (!(txn_valid && txn_addr == 8'h23) && k < 200) begin tick(); k++; end
        check("w_idx4_seen", 32'(txn_addr), 32'h23);
        wr_req = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
        k = 0;
        while (!wr_ack && k < 200) begin tick(); k++; end
        check("w_ack", 32'(wr_ack), 32'h1);
        wr_req = 1'b0;
        check("w_seg_not_updated_by_write", 32'(seg), 32'h30);
        check("w_busy_during_write", 32'(busy), 32'h1);
        wait_sweep_done("w_sweep_done");
        check("w_txn_count", 32'(tr_n - base), 32'd11);
        check("w_idx4_before_write", 32'(tr_addr[base + 4]), 32'h23);
        check("w_write_slot", 32'({tr_wr[base + 5], tr_addr[base + 5], tr_wdata[base + 5]}), 32'h12145);
        check("w_resume_idx5", 32'(tr_addr[base + 6]), 32'h22);
        check("w_seg_after_sweep", 32'(seg), 32'h45);
        check("w_ack_count", 32'(n_ack - a0), 32'd1);

        // Engine hangs: timeout abort
        hang = 1'b1; e0 = n_err;
        pulse_chs();
        k = 0;
        while (!txn_valid && k < 50) begin tick(); k++; end
        check("t_valid_seen", 32'(txn_valid), 32'h1);
        n = 0;
        while (!err && n < 100) begin tick(); n++; end
        check("t_err_latency", 32'(n), 32'd16);
        check("t_valid_low", 32'(txn_valid), 32'h0);
        check("t_busy_low", 32'(busy), 32'h0);
        check("t_year_kept", 32'(year), 32'h16);
        check("t_seg_kept", 32'(seg), 32'h45);
        tick();
        check("t_err_one_cycle", 32'(err), 32'h0);
        check("t_err_count", 32'(n_err - e0), 32'd1);
        hang = 1'b0;
        repeat (3) tick();

        // Reset asserted while waiting on a read
        d0 = n_done; a0 = n_ack;
        pulse_chs();
        k = 0;
        while (!(txn_valid && txn_addr == 8'h26) && k < 200) begin tick(); k++; end
        check("r_idx1_seen", 32'(txn_addr), 32'h26);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("r_txn_valid", 32'(txn_valid), 32'h0);
        check("r_txn_addr", 32'(txn_addr), 32'hFF);
        check("r_txn_wdata", 32'(txn_wdata), 32'hFF);
        check("r_hora", 32'(hora), 32'h80);
        check("r_year", 32'(year), 32'h00);
        check("r_seg", 32'(seg), 32'h00);
        check("r_busy", 32'(busy), 32'h0);
        check("r_flags", 32'({wr_ack, sweep_done, err, AmPm}), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        check("r_no_done", 32'(n_done - d0), 32'd0);
        check("r_no_ack", 32'(n_ack - a0), 32'd0);
        base2 = tr_n;
        pulse_chs();
        wait_sweep_done("r_resweep_done");
        check("r_restart_cmd", 32'({tr_wr[base2], tr_addr[base2]}), 32'h1F0);
        check("r_year_again", 32'(year), 32'h16);
        check("r_seg_again", 32'(seg), 32'h45);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
